ram_port_arbiter: RTL and testbench

//   Shares the simple dual-port block RAM (port A write-only, port B read-only, synchronous read)

---
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ram_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto a simple dual-port RAM (write port A, read port B) and
// routes read data back to its issuer. Define RAM_ARB_FIXED_PRIO_EN for fixed priority (req 0 wins).
module ram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0]   i_req_wdata,
    output logic [1:0]            o_req_ready,
    output logic [1:0]            o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_ram_wen,
    output logic [ADDR_W-1:0]     o_ram_waddr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    output logic [ADDR_W-1:0]     o_ram_raddr,
    input  logic [DATA_W-1:0]     i_ram_rdata
);

    logic [1:0]        w_wr_cand;
    logic [1:0]        w_rd_cand;
    logic              w_wr_win;
    logic              w_rd_win;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_hazard;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_wr_data;

    logic [ADDR_W-1:0] r_raddr;
    logic              r_tag_v  [RD_LATENCY];
    logic              r_tag_id [RD_LATENCY];

    assign w_wr_cand = i_req_valid & i_req_we;
    assign w_rd_cand = i_req_valid & ~i_req_we;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_wr_win = ~w_wr_cand[0];
    assign w_rd_win = ~w_rd_cand[0];
`else
    logic r_last_w;
    logic r_last_r;

    // On a conflict the requester that did not win last time gets the port.
    assign w_wr_win = (&w_wr_cand) ? ~r_last_w : w_wr_cand[1];
    assign w_rd_win = (&w_rd_cand) ? ~r_last_r : w_rd_cand[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_w <= 1'b1;
            r_last_r <= 1'b1;
        end else begin
            if (w_wr_gnt) r_last_w <= w_wr_win;
            if (w_rd_gnt) r_last_r <= w_rd_win;
        end
    end
`endif

    assign w_wr_addr = w_wr_win ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
    assign w_wr_data = w_wr_win ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
    assign w_rd_addr = w_rd_win ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];

    // A read colliding with this cycle's write waits one cycle so the RAM returns the new data.
    assign w_wr_gnt = (|w_wr_cand) && !i_rst;
    assign w_hazard = w_wr_gnt && (|w_rd_cand) && (w_rd_addr == w_wr_addr);
    assign w_rd_gnt = (|w_rd_cand) && !i_rst && !w_hazard;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_req_ready = 2'b00;
        if (w_wr_gnt) o_req_ready[w_wr_win] = 1'b1;
        if (w_rd_gnt) o_req_ready[w_rd_win] = 1'b1;
    end

    assign o_ram_wen   = w_wr_gnt;
    assign o_ram_waddr = w_wr_addr;
    assign o_ram_wdata = w_wr_data;
    assign o_ram_raddr = w_rd_gnt ? w_rd_addr : r_raddr;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_raddr <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_tag_v[k]  <= 1'b0;
                r_tag_id[k] <= 1'b0;
            end
        end else begin
            if (w_rd_gnt) r_raddr <= w_rd_addr;
            r_tag_v[0]  <= w_rd_gnt;
            r_tag_id[0] <= w_rd_win;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    always_comb begin
        o_rsp_valid = 2'b00;
        if (!i_rst && r_tag_v[RD_LATENCY-1]) o_rsp_valid[r_tag_id[RD_LATENCY-1]] = 1'b1;
    end

    assign o_rsp_rdata = i_ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, table-driven grant vectors, and a scoreboard that
// checks read responses (requester, data, latency) and that reset drops reads in flight.
module tb_ram_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_wen;
    logic [AW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [AW-1:0]   ram_raddr;
    logic [DW-1:0]   ram_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_ram_wen(ram_wen),
        .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata), .o_ram_raddr(ram_raddr),
        .i_ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM with LAT cycles of output latency.
    bit [DW-1:0] mem [1024];
    bit [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        rd_pipe[0] <= mem[ram_raddr];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rdata = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: reads are queued with reference data when accepted, compared on response.
    typedef struct {
        int          id;
        bit [DW-1:0] data;
        int          cyc;
    } exp_t;
    exp_t        sb[$];
    bit [DW-1:0] ref_mem [1024];

    always @(negedge clk) begin
        if (rst) begin
            check("rsp_in_reset", rsp_valid, 2'b00);
            sb.delete();
        end else begin
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", rsp_valid, (e.id == 1) ? 2'b10 : 2'b01);
                    check("rsp_data", rsp_rdata, e.data);
                    check("rsp_latency", cyc - e.cyc, LAT);
                end
            end
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i] && !req_we[i])
                    sb.push_back('{i, ref_mem[req_addr[i*AW +: AW]], cyc});
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i] && req_we[i])
                    ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    typedef struct {
        logic [1:0]    v;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0, 2'b00, 1'b0, 10'd0, 32'h0};
        tbl[1]  = '{2'b01, 2'b01, 10'd5, 10'd0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 10'd5, 32'hDEADBEEF};
        tbl[2]  = '{2'b10, 2'b00, 10'd0, 10'd5, 32'h0, 32'h0, 2'b10, 1'b0, 10'd0, 32'h0};
`ifdef RAM_ARB_FIXED_PRIO_EN
        tbl[3]  = '{2'b11, 2'b11, 10'd1, 10'd2, 32'h0101, 32'h0202, 2'b01, 1'b1, 10'd1, 32'h0101};
        tbl[4]  = '{2'b11, 2'b11, 10'd1, 10'd2, 32'h0101, 32'h0202, 2'b01, 1'b1, 10'd1, 32'h0101};
        tbl[5]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 32'h0, 2'b01, 1'b0, 10'd0, 32'h0};
        tbl[6]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 32'h0, 2'b01, 1'b0, 10'd0, 32'h0};
`else
        tbl[3]  = '{2'b11, 2'b11, 10'd1, 10'd2, 32'h0101, 32'h0202, 2'b10, 1'b1, 10'd2, 32'h0202};
        tbl[4]  = '{2'b11, 2'b11, 10'd1, 10'd2, 32'h0101, 32'h0202, 2'b01, 1'b1, 10'd1, 32'h0101};
        tbl[5]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 32'h0, 2'b01, 1'b0, 10'd0, 32'h0};
        tbl[6]  = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 32'h0, 2'b10, 1'b0, 10'd0, 32'h0};
`endif
        tbl[7]  = '{2'b11, 2'b01, 10'd7, 10'd9, 32'h11, 32'h0, 2'b11, 1'b1, 10'd7, 32'h11};
        tbl[8]  = '{2'b11, 2'b01, 10'd7, 10'd7, 32'h22, 32'h0, 2'b01, 1'b1, 10'd7, 32'h22};
        tbl[9]  = '{2'b10, 2'b00, 10'd0, 10'd7, 32'h0, 32'h0, 2'b10, 1'b0, 10'd0, 32'h0};
        tbl[10] = '{2'b00, 2'b11, 10'd3, 10'd4, 32'h5, 32'h6, 2'b00, 1'b0, 10'd0, 32'h0};
        tbl[11] = '{2'b01, 2'b11, 10'd8, 10'd8, 32'h88, 32'h99, 2'b01, 1'b1, 10'd8, 32'h88};

        // Reset held 3 cycles with both requesters active.
        req_valid = 2'b11;
        req_we    = 2'b01;
        req_addr  = {10'd6, 10'd5};
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", req_ready, 2'b00);
            check("rst_wen", ram_wen, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), req_ready, tbl[i].rdy);
            check($sformatf("vec%0d_wen", i), ram_wen, tbl[i].wen);
            if (tbl[i].wen) begin
                check($sformatf("vec%0d_waddr", i), ram_waddr, tbl[i].waddr);
                check($sformatf("vec%0d_wdata", i), ram_wdata, tbl[i].wdata);
            end
        end
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        repeat (LAT + 1) @(posedge clk);

        // Continuous reads from both requesters after a fresh reset.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {10'd2, 10'd1};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
            check("stream_grant", req_ready, 2'b01);
`else
            check("stream_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
`endif
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;

        // Read accepted, then reset: the read is dropped and both pointers return to 1.
        drive(2'b11, 2'b01, 10'd20, 10'd1, 32'h2020, 32'h0);
        @(negedge clk);
        check("pre_rst_ready", req_ready, 2'b11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 2'b00);
        end
        drive(2'b11, 2'b11, 10'd30, 10'd31, 32'h30, 32'h31);
        @(negedge clk);
        check("post_rst_wr_conflict", req_ready, 2'b01);
        drive(2'b11, 2'b00, 10'd30, 10'd31, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_rd_conflict", req_ready, 2'b01);
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        repeat (LAT + 2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
